// File: rtl/buffer_shift_array.sv
// Word-array capture/shift stage between the buffer pool read port and the MAC mesh.
// Define BSA_OUT_REG_EN to add one output register stage (latency 2).
module buffer_shift_array #(
   parameter int X_MAC = 4,
   parameter int X_MESH = 16,
   parameter int DATA_LEN = 32,
   localparam int SEL_W = $clog2(X_MAC),
   localparam int CNT_W = $clog2(X_MESH + 1)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [X_MESH*X_MAC*DATA_LEN-1:0]  din,
   input  logic [2:0]                        control,
   input  logic [X_MAC-1:0]                  iszero,
   input  logic [X_MAC*SEL_W-1:0]            buffermux,
   output logic [X_MESH*X_MAC*DATA_LEN-1:0]  dout,
   output logic [X_MAC*DATA_LEN-1:0]         row0,
   output logic                              row0_valid,
   output logic [CNT_W-1:0]                  rows_left,
   output logic                              empty
);

   localparam int ROW_W = X_MAC * DATA_LEN;
   localparam int ARR_W = X_MESH * ROW_W;

   typedef enum logic [2:0] {
      MODE_HOLD   = 3'd0,
      MODE_LOAD   = 3'd1,
      MODE_SHIFT  = 3'd2,
      MODE_ROTATE = 3'd3,
      MODE_CLEAR  = 3'd4
   } mode_e;

   logic [ARR_W-1:0] arr_q, arr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel;

   always_comb begin
      arr_d = arr_q;
      cnt_d = cnt_q;
      sel   = '0;
      case (control)
         MODE_LOAD: begin
            for (int i = 0; i < X_MESH; i++) begin
               for (int j = 0; j < X_MAC; j++) begin
                  sel = buffermux[j*SEL_W +: SEL_W];
                  arr_d[(i*X_MAC+j)*DATA_LEN +: DATA_LEN] = iszero[j] ? '0 :
                     din[(i*X_MAC+int'(sel))*DATA_LEN +: DATA_LEN];
               end
            end
            cnt_d = CNT_W'(X_MESH);
         end
         MODE_SHIFT: begin
            arr_d = {{ROW_W{1'b0}}, arr_q[ARR_W-1:ROW_W]};
            cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
         end
         MODE_ROTATE: begin
            arr_d = {arr_q[ROW_W-1:0], arr_q[ARR_W-1:ROW_W]};
         end
         MODE_CLEAR: begin
            arr_d = '0;
            cnt_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arr_q <= '0;
         cnt_q <= '0;
      end else begin
         arr_q <= arr_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef BSA_OUT_REG_EN
   logic [ARR_W-1:0] dout_q;
   logic [CNT_W-1:0] rows_q;

   // A zero count register gives empty=1 at reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
         rows_q <= '0;
      end else begin
         dout_q <= arr_q;
         rows_q <= cnt_q;
      end
   end

   assign dout      = dout_q;
   assign rows_left = rows_q;
`else
   assign dout      = arr_q;
   assign rows_left = cnt_q;
`endif

   assign row0       = dout[ROW_W-1:0];
   assign empty      = (rows_left == '0);
   assign row0_valid = (rows_left != '0);

endmodule

// File: tb/tb_buffer_shift_array.sv
// Directed bench for buffer_shift_array with a reference model and
// scoreboard queue; honours BSA_OUT_REG_EN for output latency.
module tb_buffer_shift_array;

   localparam int XM = 4;
   localparam int XR = 16;
   localparam int DL = 32;
   localparam int SW = 2;
   localparam int CW = 5;
   localparam int RW = XM * DL;
   localparam int AW = XR * RW;
`ifdef BSA_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] din;
   logic [2:0]    control;
   logic [XM-1:0] iszero;
   logic [XM*SW-1:0] buffermux;
   logic [AW-1:0] dout;
   logic [RW-1:0] row0;
   logic          row0_valid;
   logic [CW-1:0] rows_left;
   logic          empty;

   buffer_shift_array #(.X_MAC(XM), .X_MESH(XR), .DATA_LEN(DL)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .control(control),
      .iszero(iszero), .buffermux(buffermux), .dout(dout), .row0(row0),
      .row0_valid(row0_valid), .rows_left(rows_left), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w [XR][XM];
      int          cnt;
   } exp_t;

   exp_t m;
   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] mrow(exp_t e, int i);
      logic [RW-1:0] r;
      for (int j = 0; j < XM; j++) r[j*DL +: DL] = e.w[i][j];
      return r;
   endfunction

   task automatic compare(exp_t e);
      for (int i = 0; i < XR; i++)
         chk($sformatf("row%0d", i), 128'(dout[i*RW +: RW]), 128'(mrow(e, i)));
      chk("row0", 128'(row0), 128'(mrow(e, 0)));
      chk("rows_left", 128'(rows_left), 128'(e.cnt));
      chk("empty", 128'(empty), 128'(e.cnt == 0));
      chk("row0_valid", 128'(row0_valid), 128'(e.cnt != 0));
   endtask

   task automatic model_reset();
      for (int i = 0; i < XR; i++)
         for (int j = 0; j < XM; j++) m.w[i][j] = '0;
      m.cnt = 0;
   endtask

   task automatic model_step(logic [2:0] c);
      logic [31:0] r0 [XM];
      int s;
      case (c)
         3'd1: begin
            for (int i = 0; i < XR; i++)
               for (int j = 0; j < XM; j++) begin
                  s = int'(buffermux[j*SW +: SW]);
                  m.w[i][j] = iszero[j] ? 32'd0 : 32'(i*16 + s);
               end
            m.cnt = XR;
         end
         3'd2, 3'd3: begin
            for (int j = 0; j < XM; j++) r0[j] = m.w[0][j];
            for (int i = 0; i < XR-1; i++)
               for (int j = 0; j < XM; j++) m.w[i][j] = m.w[i+1][j];
            for (int j = 0; j < XM; j++)
               m.w[XR-1][j] = (c == 3'd3) ? r0[j] : 32'd0;
            if (c == 3'd2 && m.cnt > 0) m.cnt--;
         end
         3'd4: model_reset();
         default: ;
      endcase
   endtask

   task automatic step(logic [2:0] c);
      control = c;
      model_step(c);
      sb.push_back(m);
      @(posedge clk);
      #1;
      if (sb.size() >= LAT) compare(sb.pop_front());
   endtask

   task automatic flush();
      for (int k = 0; k < LAT; k++) step(3'd0);
   endtask

   function automatic logic [31:0] word(int i, int j);
      return dout[(i*XM+j)*DL +: DL];
   endfunction

   initial begin
      for (int i = 0; i < XR; i++)
         for (int j = 0; j < XM; j++)
            din[(i*XM+j)*DL +: DL] = 32'(i*16 + j);
      rst_n = 1'b0;
      control = 3'd0;
      iszero = '0;
      buffermux = '0;
      model_reset();
      #12;
      chk("rst_rows", 128'(rows_left), 128'd0);
      chk("rst_empty", 128'(empty), 128'd1);
      chk("rst_dout", 128'(dout[RW-1:0]), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) step(3'd0);

      buffermux = {2'd0, 2'd1, 2'd2, 2'd3};
      step(3'd1);
      flush();
      chk("ld_w50", 128'(word(5, 0)), 128'd83);
      chk("ld_w53", 128'(word(5, 3)), 128'd80);
      chk("ld_rows", 128'(rows_left), 128'd16);

      buffermux = {2'd3, 2'd2, 2'd1, 2'd0};
      iszero = 4'b0101;
      step(3'd1);
      flush();
      chk("zm_w70", 128'(word(7, 0)), 128'd0);
      chk("zm_w71", 128'(word(7, 1)), 128'd113);
      chk("zm_w72", 128'(word(7, 2)), 128'd0);
      chk("zm_w73", 128'(word(7, 3)), 128'd115);

      iszero = '0;
      step(3'd1);
      for (int k = 0; k < 17; k++) step(3'd2);
      flush();
      chk("sh_rows", 128'(rows_left), 128'd0);
      chk("sh_empty", 128'(empty), 128'd1);
      chk("sh_top", 128'(dout[AW-1 -: RW]), 128'd0);

      buffermux = {2'd2, 2'd2, 2'd2, 2'd2};
      step(3'd1);
      for (int k = 0; k < 16; k++) step(3'd3);
      flush();
      chk("rot_rows", 128'(rows_left), 128'd16);
      chk("rot_w91", 128'(word(9, 1)), 128'd146);
      for (int k = 0; k < 8; k++) step((k % 2 == 0) ? 3'd2 : 3'd3);
      flush();
      chk("alt_rows", 128'(rows_left), 128'd12);

      for (int c = 5; c < 8; c++) step(3'(c));
      step(3'd4);
      flush();
      chk("clr_empty", 128'(empty), 128'd1);

      buffermux = {2'd1, 2'd3, 2'd0, 2'd2};
      step(3'd1);
      for (int k = 0; k < 3; k++) step(3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dout", 128'(dout[AW-1 -: RW] | dout[RW-1:0]), 128'd0);
      chk("arst_rows", 128'(rows_left), 128'd0);
      chk("arst_empty", 128'(empty), 128'd1);
      chk("arst_valid", 128'(row0_valid), 128'd0);
      sb.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(3'd1);
      step(3'd2);
      flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/buffer_shift_array.md
Name: buffer_shift_array

Overview:
- Parametrised successor of the buffer-pool shift register. Sits between BufferPool read port (doutb) and the MAC mesh.
- Captures a full X_MESH x X_MAC word array from the pool, applying a per-lane crossbar permutation and zero mask.
- Then shifts the array row by row toward row 0, either zero-filling or rotating, and tracks how many rows remain valid.

Parameters:
- X_MAC, 4: lanes per row (power of 2, >=2).
- X_MESH, 16: rows in the array (>=2).
- DATA_LEN, 32: bits per word.
- SEL_W, $clog2(X_MAC): width of one buffermux field (derived localparam).
- CNT_W, $clog2(X_MESH+1): width of the row counter (derived localparam).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- din, in, X_MESH*X_MAC*DATA_LEN: pool data. Word (i,j) is at [(i*X_MAC+j)*DATA_LEN +: DATA_LEN].
- control, in, 3: mode select (see Behaviour).
- iszero, in, X_MAC: per-lane zero mask, applied on LOAD.
- buffermux, in, X_MAC*SEL_W: output lane j takes din lane buffermux[j*SEL_W +: SEL_W], applied on LOAD.
- dout, out, X_MESH*X_MAC*DATA_LEN: registered array, same packing as din.
- row0, out, X_MAC*DATA_LEN: alias of dout row 0.
- row0_valid, out, 1: row 0 holds loaded (not fill) data.
- rows_left, out, CNT_W: number of loaded rows still in the array.
- empty, out, 1: high when rows_left==0.

Behaviour:
- Reset (async, rst_n=0): dout=0, rows_left=0, empty=1, row0_valid=0. Reset asserted mid-shift aborts immediately; there is no residual state.
- control is sampled each rising clk. Array updates one cycle after control (latency 1).
- 0 HOLD: no change.
- 1 LOAD:
  - For every row i and lane j: dout(i,j) <= iszero[j] ? 0 : din(i, buffermux field j).
  - rows_left <= X_MESH.
  - Duplicate mux selects are legal (broadcast).
- 2 SHIFT: dout(i) <= dout(i+1) for i<X_MESH-1; dout(X_MESH-1) <= 0. rows_left decrements, saturating at 0.
- 3 ROTATE: dout(i) <= dout(i+1); dout(X_MESH-1) <= old dout(0). rows_left unchanged.
- 4 CLEAR: dout <= 0, rows_left <= 0.
- 5-7: reserved, treated as HOLD. No X propagation.
- Derived outputs, all registered-consistent and combinational from state:
  - empty = (rows_left==0).
  - row0_valid = (rows_left!=0).
- SHIFT when empty: array still shifts (zeros stay zero); rows_left stays 0.
- LOAD has priority by encoding only: one mode per cycle, no simultaneous-event arbitration needed.
- Alternating SHIFT/ROTATE (2,3,2,3...) is legal. Each SHIFT consumes one row; each ROTATE recirculates one row.

Optional Feature:
- Macro BSA_OUT_REG_EN.
- Defined: dout, row0, row0_valid, rows_left and empty pass through one extra output register stage (reset 0, empty reset 1). Observed latency becomes 2 cycles; internal state behaviour is unchanged.
- Undefined: outputs are driven directly from the state registers, latency 1.

Test Plan (X_MAC=4, X_MESH=16, DATA_LEN=32; din(i,j)=i*16+j):
- Reset then HOLD for 3 cycles -> dout all 0, empty=1, rows_left=0.
- LOAD with buffermux fields {3,2,1,0} (lane0 field=3) and iszero=0 -> next cycle dout(i,0)=i*16+3 and dout(i,3)=i*16; rows_left=16; row0_valid=1.
- LOAD with iszero=4'b0101 -> lanes 0 and 2 are 0 in all rows; lanes 1 and 3 are correct.
- LOAD, then 16 SHIFTs -> after k shifts row0 = loaded row k and rows_left=16-k. After the 16th shift: dout all 0, empty=1. A 17th SHIFT keeps rows_left=0.
- LOAD, then 16 ROTATEs -> dout equals the loaded image and rows_left=16 throughout. Alternating 2/3 for 8 cycles leaves rows_left=12.
- Assert rst_n low asynchronously mid-shift (between clock edges) -> outputs go to reset values immediately, without waiting for clk. With BSA_OUT_REG_EN defined, the LOAD result appears 2 cycles after control.
